seq_alu: RTL and testbench



---
 rtl/seq_alu.sv | 145 ++++++++++++++
 tb/tb_seq_alu.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU for the 16-bit CPU: single-cycle ops plus an iterative
// one-bit-per-cycle logical shift left, behind a start/busy/done handshake.
module seq_alu #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned SHAMT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       alu_code,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow
);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_e;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_LSL = 3'b010,
      OP_SLT = 3'b011,
      OP_AND = 3'b100,
      OP_OR  = 3'b101,
      OP_NOT = 3'b110,
      OP_XOR = 3'b111
   } op_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic               ovf_q, ovf_d;
   logic               done_q, done_d;

   op_e                op;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0]   sum, diff, op_res;
   logic               op_ovf;
   logic               lt;

   assign op    = op_e'(alu_code);
   assign shamt = b[SHAMT_W-1:0];
   assign sum   = a + b;
   assign diff  = a - b;
   assign lt    = $signed(a) < $signed(b);

   // Result of any op that finishes on the accepting edge (incl. lsl by 0 or 1).
   always_comb begin
      op_res = '0;
      op_ovf = 1'b0;
      unique case (op)
         OP_ADD: begin
            op_res = sum;
            op_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            op_res = diff;
            op_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_LSL: op_res = (shamt == '0) ? a : (a << 1);
         OP_SLT: op_res = {{(WIDTH-1){1'b0}}, lt};
         OP_AND: op_res = a & b;
         OP_OR:  op_res = a | b;
         OP_NOT: op_res = ~a;
         OP_XOR: op_res = a ^ b;
         default: op_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      done_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (op == OP_LSL && shamt != '0) begin
                  acc_d = a << 1;
                  cnt_d = shamt - 1'b1;
               end
               if (op == OP_LSL && shamt > SHAMT_W'(1)) begin
                  state_d = SHIFT;
               end else begin
                  result_d = op_res;
                  zero_d   = (op_res == '0);
                  ovf_d    = op_ovf;
                  done_d   = 1'b1;
               end
            end
         end
         SHIFT: begin
            acc_d = acc_q << 1;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == SHAMT_W'(1)) begin
               result_d = acc_q << 1;
               zero_d   = ((acc_q << 1) == '0);
               ovf_d    = 1'b0;
               done_d   = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
      end
   end

   assign busy     = (state_q == SHIFT);
   assign done     = done_q;
   assign result   = result_q;
   assign zero     = zero_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  alu_code;
   logic [15:0] a, b;
   logic        busy, done, zero, overflow;
   logic [15:0] result;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(16), .SHAMT_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .alu_code (alu_code),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .zero     (zero),
      .overflow (overflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: signed math via int, shifts via multiplication modulo 2^16.
   task automatic model(input logic [2:0] code, input logic [15:0] x, input logic [15:0] y,
                        output logic [15:0] res, output logic ovf, output int lat);
      int sx, sy, r, k;
      sx  = int'($signed(x));
      sy  = int'($signed(y));
      k   = int'(y % 16);
      ovf = 1'b0;
      lat = 1;
      case (code)
         3'd0: begin r = sx + sy; ovf = (r > 32767) || (r < -32768); res = 16'(r); end
         3'd1: begin r = sx - sy; ovf = (r > 32767) || (r < -32768); res = 16'(r); end
         3'd2: begin res = 16'((int'(x) * (2 ** k)) % 65536); lat = (k == 0) ? 1 : k; end
         3'd3: res = (sx < sy) ? 16'd1 : 16'd0;
         3'd4: res = x & y;
         3'd5: res = x | y;
         3'd6: res = ~x;
         default: res = x ^ y;
      endcase
   endtask

   // Issue one op, wait for done (bounded), check latency/busy/result; poke
   // raises an ignored add during the first busy cycle.
   task automatic do_op(input logic [2:0] code, input logic [15:0] x, input logic [15:0] y,
                        input bit poke);
      logic [15:0] er;
      logic        eo;
      int          el, lat, bcnt;
      model(code, x, y, er, eo, el);
      start = 1'b1; alu_code = code; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0; a = 16'($urandom); b = 16'($urandom); alu_code = 3'($urandom);
      lat = 1; bcnt = 0;
      while (!done && lat < 40) begin
         if (busy) bcnt++;
         if (poke && lat == 1) begin
            start = 1'b1; alu_code = 3'd0; a = 16'd2; b = 16'd3;
         end
         @(posedge clk); #1;
         start = 1'b0;
         lat++;
      end
      check("done", 32'(done), 32'd1);
      check("latency", 32'(lat), 32'(el));
      check("busy_cycles", 32'(bcnt), 32'(el - 1));
      check("busy_at_done", 32'(busy), 32'd0);
      check("result", 32'(result), 32'(er));
      check("zero", 32'(zero), 32'(er == 16'd0));
      check("overflow", 32'(overflow), 32'(eo));
      @(posedge clk); #1;
      check("done_pulse", 32'(done), 32'd0);
      check("result_held", 32'(result), 32'(er));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; alu_code = '0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_zero", 32'(zero), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);

      do_op(3'd0, 16'h7FFF, 16'h0001, 1'b0);

      // back-to-back sub then xor
      start = 1'b1; alu_code = 3'd1; a = 16'h1234; b = 16'h1234;
      @(posedge clk); #1;
      alu_code = 3'd7; a = 16'h00FF; b = 16'h0F0F;
      check("b2b_done1", 32'(done), 32'd1);
      check("b2b_res1", 32'(result), 32'h0000);
      check("b2b_zero1", 32'(zero), 32'd1);
      check("b2b_ovf1", 32'(overflow), 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b_done2", 32'(done), 32'd1);
      check("b2b_res2", 32'(result), 32'h0FF0);
      check("b2b_zero2", 32'(zero), 32'd0);
      @(posedge clk); #1;
      check("b2b_done3", 32'(done), 32'd0);

      do_op(3'd3, 16'hFFFF, 16'h0001, 1'b0);
      do_op(3'd3, 16'h0001, 16'hFFFF, 1'b0);
      do_op(3'd6, 16'h00F0, 16'h1234, 1'b0);
      do_op(3'd2, 16'h0003, 16'h0004, 1'b1);
      do_op(3'd2, 16'h8001, 16'h0000, 1'b0);
      do_op(3'd2, 16'h8001, 16'h000F, 1'b0);
      do_op(3'd2, 16'h1234, 16'h0001, 1'b0);
      do_op(3'd1, 16'h8000, 16'h0001, 1'b0);

      // reset in the 5th busy cycle of a long shift
      start = 1'b1; alu_code = 3'd2; a = 16'h0001; b = 16'h000F;
      @(posedge clk); #1;
      start = 1'b0;
      check("rs_busy1", 32'(busy), 32'd1);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rs_busy", 32'(busy), 32'd0);
      check("rs_done", 32'(done), 32'd0);
      check("rs_result", 32'(result), 32'd0);
      check("rs_zero", 32'(zero), 32'd0);
      begin
         int seen = 0;
         for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
         end
         check("rs_no_done", 32'(seen), 32'd0);
      end
      do_op(3'd0, 16'd2, 16'd3, 1'b0);

      // reset wins over a simultaneous start
      rst = 1'b1; start = 1'b1; alu_code = 3'd0; a = 16'd7; b = 16'd8;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      check("rp_done", 32'(done), 32'd0);
      check("rp_result", 32'(result), 32'd0);
      @(posedge clk); #1;
      check("rp_done2", 32'(done), 32'd0);

      for (int n = 0; n < 80; n++) begin
         logic [2:0]  c;
         logic [15:0] x, y;
         c = 3'($urandom);
         x = 16'($urandom);
         y = 16'($urandom);
         if ($urandom_range(0, 3) == 0) y = x;
         if ($urandom_range(0, 3) == 0) x = 16'h8000 ^ 16'($urandom_range(0, 1));
         do_op(c, x, y, 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
